arbiter_request_buffer: RTL and testbench

//   Agent-side counterpart of a round-robin arbiter: buffers outgoing words from a local source,

---
 rtl/arb_pkg.sv | 9 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/arbiter_request_buffer.sv | 94 +++++++++
 tb/tb_arbiter_request_buffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared defaults for the arbiter request buffer and its FIFO.
// STARVE_LIMIT_DEF is only used when STARVATION_MONITOR_EN is defined.
package arb_pkg;
   localparam int DATA_WIDTH_DEF   = 32;
   localparam int DEPTH_DEF        = 4;
   localparam int STARVE_LIMIT_DEF = 15;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO: storage, naturally wrapping rd/wr pointers, occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module sync_fifo
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/arbiter_request_buffer.sv
// Agent-side request buffer: queues words, requests while non-empty, releases one word per grant.
// Optional starvation monitor (starved_o) built when STARVATION_MONITOR_EN is defined.
module arbiter_request_buffer
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
`ifdef STARVATION_MONITOR_EN
   ,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  request_o,
   input  logic                  grant_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
`ifdef STARVATION_MONITOR_EN
   ,
   output logic                  starved_o
`endif
);
   logic                  full, empty, push, pop;
   logic [DATA_WIDTH-1:0] head;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   // ready/request come only from FIFO registers, so grant_i never reaches them combinationally.
   assign ready_o   = !full;
   assign request_o = !empty;
   assign push      = valid_i & ready_o;
   assign pop       = grant_i & request_o;

   sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .pop_i  (pop),
      .wdata_i(data_i),
      .rdata_o(head),
      .full_o (full),
      .empty_o(empty)
   );

   always_comb begin
      valid_d = pop;
      data_d  = pop ? head : data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef STARVATION_MONITOR_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!request_o || pop) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign starved_o = (starve_cnt_q == SW'(STARVE_LIMIT));
`endif
endmodule

// File: tb/tb_arbiter_request_buffer.sv
// Directed vector table plus reset, random-traffic and starvation sequences for arbiter_request_buffer.
module tb_arbiter_request_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        grant_i = 1'b0;
   logic        ready_o, request_o, valid_o;
   logic [31:0] data_o;
`ifdef STARVATION_MONITOR_EN
   logic        starved_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   arbiter_request_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .ready_o  (ready_o),
      .request_o(request_o),
      .grant_i  (grant_i),
      .valid_o  (valid_o),
      .data_o   (data_o)
`ifdef STARVATION_MONITOR_EN
      ,
      .starved_o(starved_o)
`endif
   );

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        g;
      logic        rdy;
      logic        req;
      logic        vo;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic v, logic [31:0] d, logic g,
                               logic rdy, logic req, logic vo, logic [31:0] dout);
      vec_t r;
      r.v = v; r.d = d; r.g = g; r.rdy = rdy; r.req = req; r.vo = vo; r.dout = dout;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, settle 1 time unit past it.
   task automatic step(input logic v, input logic [31:0] d, input logic g);
      valid_i = v;
      data_i  = d;
      grant_i = g;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [31:0] last_do;
   logic        v, g, pop_m, push_m;
   logic [31:0] d;

   initial begin
      // state after each step: ready, request, valid_o, data_o
      vecs[0]  = mk(1, 32'hA1, 1, 1, 1, 0, 32'h0);   // grant while empty ignored, push A1
      vecs[1]  = mk(0, 32'h0,  1, 1, 0, 1, 32'hA1);  // pop A1, request drops
      vecs[2]  = mk(0, 32'h0,  1, 1, 0, 0, 32'hA1);  // grant while empty
      vecs[3]  = mk(1, 32'hB0, 0, 1, 1, 0, 32'hA1);
      vecs[4]  = mk(1, 32'hB1, 0, 1, 1, 0, 32'hA1);
      vecs[5]  = mk(1, 32'hB2, 0, 1, 1, 0, 32'hA1);
      vecs[6]  = mk(1, 32'hB3, 0, 0, 1, 0, 32'hA1);  // full
      vecs[7]  = mk(1, 32'hB4, 0, 0, 1, 0, 32'hA1);  // 5th word refused
      vecs[8]  = mk(1, 32'hC0, 1, 1, 1, 1, 32'hB0);  // full + grant: pop only
      vecs[9]  = mk(1, 32'hC0, 0, 0, 1, 0, 32'hB0);  // push now accepted, full again
      vecs[10] = mk(0, 32'h0,  1, 1, 1, 1, 32'hB1);
      vecs[11] = mk(0, 32'h0,  1, 1, 1, 1, 32'hB2);
      vecs[12] = mk(1, 32'hC1, 1, 1, 1, 1, 32'hB3);  // push and pop together
      vecs[13] = mk(0, 32'h0,  1, 1, 1, 1, 32'hC0);
      vecs[14] = mk(0, 32'h0,  1, 1, 0, 1, 32'hC1);
      vecs[15] = mk(0, 32'h0,  1, 1, 0, 0, 32'hC1);

      #2;
      chk("rst_ready",   {31'b0, ready_o},   32'd1);
      chk("rst_request", {31'b0, request_o}, 32'd0);
      chk("rst_valid",   {31'b0, valid_o},   32'd0);
      chk("rst_data",    data_o,             32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].v, vecs[i].d, vecs[i].g);
         chk($sformatf("vec%0d_ready", i),   {31'b0, ready_o},   {31'b0, vecs[i].rdy});
         chk($sformatf("vec%0d_request", i), {31'b0, request_o}, {31'b0, vecs[i].req});
         chk($sformatf("vec%0d_valid", i),   {31'b0, valid_o},   {31'b0, vecs[i].vo});
         chk($sformatf("vec%0d_data", i),    data_o,             vecs[i].dout);
      end

      // reset with words queued
      step(1, 32'hD0, 0);
      step(1, 32'hD1, 0);
      chk("pre_rst_request", {31'b0, request_o}, 32'd1);
      valid_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_request", {31'b0, request_o}, 32'd0);
      chk("async_rst_ready",   {31'b0, ready_o},   32'd1);
      chk("async_rst_valid",   {31'b0, valid_o},   32'd0);
      chk("async_rst_data",    data_o,             32'd0);
      @(posedge clk);
      #1;
      chk("hold_rst_request", {31'b0, request_o}, 32'd0);
      rst = 1'b1;
      step(0, 32'h0, 1);
      chk("post_rst_request", {31'b0, request_o}, 32'd0);
      chk("post_rst_valid",   {31'b0, valid_o},   32'd0);
      chk("post_rst_data",    data_o,             32'd0);

      // random traffic against a queue model
      last_do = 32'h0;
      for (int i = 0; i < 100; i++) begin
         v = 1'($urandom_range(0, 1));
         g = ($urandom_range(0, 2) == 0);
         d = $urandom;
         pop_m  = g && (q.size() != 0);
         push_m = v && (q.size() != 4);
         if (pop_m) last_do = q.pop_front();
         if (push_m) q.push_back(d);
         step(v, d, g);
         chk($sformatf("rnd%0d_request", i), {31'b0, request_o}, {31'b0, q.size() != 0});
         chk($sformatf("rnd%0d_ready", i),   {31'b0, ready_o},   {31'b0, q.size() != 4});
         chk($sformatf("rnd%0d_valid", i),   {31'b0, valid_o},   {31'b0, pop_m});
         chk($sformatf("rnd%0d_data", i),    data_o,             last_do);
      end

`ifdef STARVATION_MONITOR_EN
      valid_i = 1'b0;
      grant_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      step(1, 32'hE0, 0);
      for (int i = 0; i < 14; i++) step(0, 32'h0, 0);
      chk("starve_14", {31'b0, starved_o}, 32'd0);
      step(0, 32'h0, 0);
      chk("starve_15", {31'b0, starved_o}, 32'd1);
      step(0, 32'h0, 0);
      chk("starve_sat", {31'b0, starved_o}, 32'd1);
      step(0, 32'h0, 1);
      chk("starve_clear", {31'b0, starved_o}, 32'd0);
      chk("starve_pop_data", data_o, 32'hE0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
